// File: rtl/gate_vector_checker.sv
// gate_vector_checker: sweeps a/b over 00,01,10,11 and checks c against a truth table.
// Optional GATE_CHK_FIRSTFAIL_EN adds first_fail_vld/first_fail_vec outputs.
module gate_vector_checker #(
    parameter int         SETTLE_CYCLES = 1,
    parameter int         REPEAT        = 1,
    parameter logic [3:0] EXPECT        = 4'b0111,
    parameter int         ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             c,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
`ifdef GATE_CHK_FIRSTFAIL_EN
    output logic             first_fail_vld,
    output logic [1:0]       first_fail_vec,
`endif
    output logic [ERR_W-1:0] err_count
);
    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    localparam logic [7:0] SET_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] RPT_LAST = 8'(REPEAT - 1);

    state_t state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [7:0] sweep_q, sweep_d, set_q, set_d;
    logic a_q, a_d, b_q, b_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic ff_vld_q, ff_vld_d;
    logic [1:0] ff_vec_q, ff_vec_d;
    logic mis;

    // Case-inequality so an X on c counts as a mismatch.
    assign mis = (c !== EXPECT[vec_q]);

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        sweep_d  = sweep_q;
        set_d    = set_q;
        a_d      = a_q;
        b_d      = b_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        ff_vld_d = ff_vld_q;
        ff_vec_d = ff_vec_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d  = APPLY;
                vec_d    = 2'd0;
                sweep_d  = 8'd0;
                set_d    = 8'd0;
                a_d      = 1'b0;
                b_d      = 1'b0;
                busy_d   = 1'b1;
                done_d   = 1'b0;
                pass_d   = 1'b0;
                err_d    = '0;
                ff_vld_d = 1'b0;
                ff_vec_d = 2'd0;
            end
            APPLY: begin
                state_d = (set_q == SET_LAST) ? CHECK : APPLY;
                set_d   = (set_q == SET_LAST) ? 8'd0 : set_q + 8'd1;
            end
            default: begin
                if (mis) begin
                    err_d = (err_q == '1) ? err_q : err_q + ERR_W'(1);
                    if (!ff_vld_q) begin
                        ff_vld_d = 1'b1;
                        ff_vec_d = {a_q, b_q};
                    end
                end
                if (vec_q != 2'd3) begin
                    state_d    = APPLY;
                    vec_d      = vec_q + 2'd1;
                    {a_d, b_d} = vec_q + 2'd1;
                end else if (sweep_q < RPT_LAST) begin
                    state_d    = APPLY;
                    vec_d      = 2'd0;
                    sweep_d    = sweep_q + 8'd1;
                    {a_d, b_d} = 2'd0;
                end else begin
                    state_d    = DONE;
                    {a_d, b_d} = 2'd0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    pass_d     = (err_d == '0);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            vec_q    <= 2'd0;
            sweep_q  <= 8'd0;
            set_q    <= 8'd0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            ff_vld_q <= 1'b0;
            ff_vec_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            sweep_q  <= sweep_d;
            set_q    <= set_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            ff_vld_q <= ff_vld_d;
            ff_vec_q <= ff_vec_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
`ifdef GATE_CHK_FIRSTFAIL_EN
    assign first_fail_vld = ff_vld_q;
    assign first_fail_vec = ff_vec_q;
`endif
endmodule

// File: tb/tb_gate_vector_checker.sv
// tb_gate_vector_checker: scoreboard bench over several parameterisations of gate_vector_checker.
module tb_gate_vector_checker;
    typedef struct {int err; int pass; int done_at; int ffvec;} res_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    int mode = 0;
    int tests = 0, fails = 0;
    res_t res_q[$];
    logic [1:0] ab_q[$];

    always #5 clk = ~clk;

    logic a0, b0, busy0, done0, pass0, c0;
    logic a1, b1, busy1, done1, pass1, c1;
    logic a2, b2, busy2, done2, pass2, c2;
    logic a3, b3, busy3, done3, pass3, c3;
    logic [3:0] err0, err1, err2;
    logic [1:0] err3;
`ifdef GATE_CHK_FIRSTFAIL_EN
    logic ffv0, ffv1, ffv2, ffv3;
    logic [1:0] ffc0, ffc1, ffc2, ffc3;
`endif

    function automatic logic cfun(int m, logic [1:0] v);
        case (m)
            0:       return ~(v[1] & v[0]);
            1:       return 1'b0;
            2:       return v[1] & v[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic res_t model(logic [3:0] e, int rep, int m, int errw);
        res_t r;
        r.err = 0;
        r.ffvec = -1;
        for (int s = 0; s < rep; s++)
            for (int v = 0; v < 4; v++) begin
                logic [1:0] vv;
                vv = 2'(v);
                if (cfun(m, vv) != e[vv]) begin
                    r.err++;
                    if (r.ffvec < 0) r.ffvec = v;
                end
            end
        if (r.err > 2 ** errw - 1) r.err = 2 ** errw - 1;
        r.pass = (r.err == 0);
        r.done_at = 4 * rep * 2;
        return r;
    endfunction

    assign c0 = cfun(mode, {a0, b0});
    assign c1 = a1 & b1;
    assign c2 = 1'b1;
    assign c3 = a3 & b3;

    gate_vector_checker u0 (
        .clk(clk), .rst(rst), .start(start), .c(c0), .a(a0), .b(b0), .busy(busy0), .done(done0),
`ifdef GATE_CHK_FIRSTFAIL_EN
        .first_fail_vld(ffv0), .first_fail_vec(ffc0),
`endif
        .pass(pass0), .err_count(err0));
    gate_vector_checker #(.EXPECT(4'b1000)) u1 (
        .clk(clk), .rst(rst), .start(start), .c(c1), .a(a1), .b(b1), .busy(busy1), .done(done1),
`ifdef GATE_CHK_FIRSTFAIL_EN
        .first_fail_vld(ffv1), .first_fail_vec(ffc1),
`endif
        .pass(pass1), .err_count(err1));
    gate_vector_checker #(.REPEAT(3)) u2 (
        .clk(clk), .rst(rst), .start(start), .c(c2), .a(a2), .b(b2), .busy(busy2), .done(done2),
`ifdef GATE_CHK_FIRSTFAIL_EN
        .first_fail_vld(ffv2), .first_fail_vec(ffc2),
`endif
        .pass(pass2), .err_count(err2));
    gate_vector_checker #(.REPEAT(2), .ERR_W(2)) u3 (
        .clk(clk), .rst(rst), .start(start), .c(c3), .a(a3), .b(b3), .busy(busy3), .done(done3),
`ifdef GATE_CHK_FIRSTFAIL_EN
        .first_fail_vld(ffv3), .first_fail_vec(ffc3),
`endif
        .pass(pass3), .err_count(err3));

    task automatic check(string tag, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(int m, bit extra);
        int dat[4];
        int n;
        res_t r;
        dat = '{-1, -1, -1, -1};
        n = 0;
        mode = m;
        for (int k = 0; k <= 8; k++) ab_q.push_back(k < 8 ? 2'((k / 2) % 4) : 2'b00);
        res_q.push_back(model(4'b0111, 1, m, 4));
        res_q.push_back(model(4'b1000, 1, 2, 4));
        res_q.push_back(model(4'b0111, 3, 3, 4));
        res_q.push_back(model(4'b0111, 2, 2, 2));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (n <= 60) begin
            if (n <= 8) begin
                logic [1:0] e;
                e = ab_q.pop_front();
                check($sformatf("m%0d ab@%0d", m, n), int'({a0, b0}), int'(e));
            end
            start = (extra && n == 3);
            if (done0 && dat[0] < 0) dat[0] = n;
            if (done1 && dat[1] < 0) dat[1] = n;
            if (done2 && dat[2] < 0) dat[2] = n;
            if (done3 && dat[3] < 0) dat[3] = n;
            if (dat[0] >= 0 && dat[1] >= 0 && dat[2] >= 0 && dat[3] >= 0) break;
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        r = res_q.pop_front();
        check($sformatf("m%0d u0 done_at", m), dat[0], r.done_at);
        check($sformatf("m%0d u0 err", m), int'(err0), r.err);
        check($sformatf("m%0d u0 pass", m), int'(pass0), r.pass);
        check($sformatf("m%0d u0 busy", m), int'(busy0), 0);
`ifdef GATE_CHK_FIRSTFAIL_EN
        check($sformatf("m%0d u0 ffvld", m), int'(ffv0), int'(r.ffvec >= 0));
        if (r.ffvec >= 0) check($sformatf("m%0d u0 ffvec", m), int'(ffc0), r.ffvec);
`endif
        r = res_q.pop_front();
        check("u1 done_at", dat[1], r.done_at);
        check("u1 err", int'(err1), r.err);
        check("u1 pass", int'(pass1), r.pass);
        r = res_q.pop_front();
        check("u2 done_at", dat[2], r.done_at);
        check("u2 err", int'(err2), r.err);
        check("u2 pass", int'(pass2), r.pass);
        r = res_q.pop_front();
        check("u3 done_at", dat[3], r.done_at);
        check("u3 err", int'(err3), r.err);
        check("u3 pass", int'(pass3), r.pass);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst ab", int'({a0, b0}), 0);
        check("rst busy", int'(busy0), 0);
        check("rst done", int'(done0), 0);
        check("rst pass", int'(pass0), 0);
        check("rst err", int'(err0), 0);
        rst = 1'b0;
        run(0, 1'b0);
        run(1, 1'b0);
        run(2, 1'b0);
        run(3, 1'b0);
        run(0, 1'b1);
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid ab", int'({a0, b0}), 2);
        check("mid err", int'(err0), 2);
        check("mid busy", int'(busy0), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst ab", int'({a0, b0}), 0);
        check("mrst busy", int'(busy0), 0);
        check("mrst done", int'(done0), 0);
        check("mrst err", int'(err0), 0);
        repeat (3) @(posedge clk);
        #1;
        check("idle ab", int'({a0, b0}), 0);
        check("idle busy", int'(busy0), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
